// File: rtl/io_tape_pkg.sv
// Shared constants, FSM state encoding and address helper for the tape loader.
package io_tape_pkg;

    localparam int FRAMES_PER_WORD = 8;
    localparam int FRAME_W         = 4;
    localparam int WORD_W          = 31;
    localparam int ADDR_W          = 12;
    localparam int SHIFT_W         = FRAMES_PER_WORD * FRAME_W;
    localparam int CNT_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSEMBLE   = 3'd1,
        ST_WRITE_REQ  = 3'd2,
        ST_WRITE_WAIT = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Word addresses wrap 12'o7777 -> 12'o0000 through natural 12-bit overflow.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return addr + 12'd1;
    endfunction

endpackage

// File: rtl/io_tape_loader_if.sv
// Tape-frame handshake plus the memory IO write port, grouped as one bus.
interface io_tape_loader_if;
    import io_tape_pkg::*;

    logic                frame_valid;
    logic [FRAME_W-1:0]  frame_data;
    logic                frame_ready;
    logic [ADDR_W-1:0]   addr_to_sel;
    logic                write_sign_to_mem;
    logic [WORD_W-2:0]   write_data_to_mem;
    logic                mem_write_from_io;
    logic                mem_write_reply_to_io;

    modport master (
        input  frame_valid, frame_data, mem_write_reply_to_io,
        output frame_ready, addr_to_sel, write_sign_to_mem, write_data_to_mem, mem_write_from_io
    );

    modport slave (
        output frame_valid, frame_data, mem_write_reply_to_io,
        input  frame_ready, addr_to_sel, write_sign_to_mem, write_data_to_mem, mem_write_from_io
    );

endinterface

// File: rtl/io_frame_shifter.sv
// 32-bit MSB-first frame shift register with a frame counter; strobes on the 8th frame.
module io_frame_shifter
    import io_tape_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [FRAME_W-1:0] frame_data,
    output logic [SHIFT_W-1:0] shift_next,
    output logic               word_complete
);

    logic [SHIFT_W-1:0] shift_r;
    logic [CNT_W-1:0]   cnt_r;

    assign shift_next    = {shift_r[SHIFT_W-FRAME_W-1:0], frame_data};
    assign word_complete = shift_en && (cnt_r == 3'd7);

    // Shift register and frame counter; counter wraps to 0 after each full word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_r <= {SHIFT_W{1'b0}};
            cnt_r   <= 3'd0;
        end else if (clear) begin
            shift_r <= {SHIFT_W{1'b0}};
            cnt_r   <= 3'd0;
        end else if (shift_en) begin
            shift_r <= shift_next;
            cnt_r   <= cnt_r + 3'd1;
        end
    end

endmodule

// File: rtl/io_tape_loader.sv
// Tape block loader: assembles 8 frames per word and writes words to memory.
// Optional trailing checksum word when IO_TAPE_LOADER_CHECKSUM_EN is defined.
module io_tape_loader
    import io_tape_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_from_pnl,
    input  logic                 abort_from_pnl,
    input  logic [ADDR_W-1:0]    start_addr_from_pnl,
    input  logic [ADDR_W-1:0]    word_count_from_pnl,
    io_tape_loader_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

`ifdef IO_TAPE_LOADER_CHECKSUM_EN
    localparam state_t ST_LAST = ST_CHECK;
`else
    localparam state_t ST_LAST = ST_DONE;
`endif

    state_t             state_r, state_next;
    logic [ADDR_W-1:0]  addr_r, remaining_r;
    logic [WORD_W-1:0]  word_r;
    logic               frame_ready_r, mem_write_r, busy_r, done_r, error_r, abort_pend_r;
    logic               start_s, accept_s, word_done_s, reply_s, err_set_s;
    logic               in_write_s, in_write_next_s;
    logic [SHIFT_W-1:0] shift_next_s;

    assign start_s         = (state_r == ST_IDLE) && start_from_pnl;
    assign accept_s        = bus.frame_valid && frame_ready_r;
    assign reply_s         = (state_r == ST_WRITE_WAIT) && bus.mem_write_reply_to_io;
    assign in_write_s      = (state_r == ST_WRITE_REQ) || (state_r == ST_WRITE_WAIT);
    assign in_write_next_s = (state_next == ST_WRITE_REQ) || (state_next == ST_WRITE_WAIT);

    io_frame_shifter u_shifter (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (start_s),
        .shift_en      (accept_s),
        .frame_data    (bus.frame_data),
        .shift_next    (shift_next_s),
        .word_complete (word_done_s)
    );

`ifdef IO_TAPE_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_r;
    logic              sum_bad_s;
    assign sum_bad_s = (shift_next_s[WORD_W-1:0] != sum_r);

    // Running modulo-2^31 sum of every word that goes to memory.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sum_r <= {WORD_W{1'b0}};
        end else if (start_s) begin
            sum_r <= {WORD_W{1'b0}};
        end else if ((state_r == ST_ASSEMBLE) && word_done_s && !abort_from_pnl) begin
            sum_r <= sum_r + shift_next_s[WORD_W-1:0];
        end
    end
`endif

    // Next-state and error-set decode; aborts during a write wait for the reply.
    always_comb begin
        state_next = state_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_from_pnl) begin
                    state_next = (word_count_from_pnl == 12'd0) ? ST_DONE : ST_ASSEMBLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ASSEMBLE: begin
                if (abort_from_pnl) begin
                    state_next = ST_IDLE;
                    err_set_s  = 1'b1;
                end else if (word_done_s) begin
                    state_next = ST_WRITE_REQ;
                    err_set_s  = shift_next_s[SHIFT_W-1];
                end else begin
                    state_next = ST_ASSEMBLE;
                end
            end
            ST_WRITE_REQ: state_next = ST_WRITE_WAIT;
            ST_WRITE_WAIT: begin
                if (bus.mem_write_reply_to_io) begin
                    if (abort_pend_r || abort_from_pnl) begin
                        state_next = ST_IDLE;
                        err_set_s  = 1'b1;
                    end else if (remaining_r == 12'd1) begin
                        state_next = ST_LAST;
                    end else begin
                        state_next = ST_ASSEMBLE;
                    end
                end else begin
                    state_next = ST_WRITE_WAIT;
                end
            end
`ifdef IO_TAPE_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (abort_from_pnl) begin
                    state_next = ST_IDLE;
                    err_set_s  = 1'b1;
                end else if (word_done_s) begin
                    state_next = ST_DONE;
                    err_set_s  = sum_bad_s;
                end else begin
                    state_next = ST_CHECK;
                end
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, registered outputs and transfer bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_write_r   <= 1'b0;
            frame_ready_r <= 1'b0;
            error_r       <= 1'b0;
            abort_pend_r  <= 1'b0;
            addr_r        <= 12'd0;
            remaining_r   <= 12'd0;
            word_r        <= {WORD_W{1'b0}};
        end else begin
            state_r       <= state_next;
            busy_r        <= (state_next != ST_IDLE);
            done_r        <= (state_next == ST_DONE);
            mem_write_r   <= (state_next == ST_WRITE_REQ);
            frame_ready_r <= (state_next == ST_ASSEMBLE) || (state_next == ST_CHECK);
            abort_pend_r  <= in_write_next_s && (abort_pend_r || (in_write_s && abort_from_pnl));
            if (start_s) begin
                error_r <= 1'b0;
            end else if (err_set_s) begin
                error_r <= 1'b1;
            end
            if (start_s) begin
                addr_r      <= start_addr_from_pnl;
                remaining_r <= word_count_from_pnl;
            end else if (reply_s) begin
                addr_r      <= next_addr(addr_r);
                remaining_r <= remaining_r - 12'd1;
            end
            // Bit 31 of the shifter is dropped; the word is captured for the request cycle.
            if ((state_r == ST_ASSEMBLE) && word_done_s) begin
                word_r <= shift_next_s[WORD_W-1:0];
            end
        end
    end

    assign bus.frame_ready       = frame_ready_r;
    assign bus.addr_to_sel       = addr_r;
    assign bus.write_sign_to_mem = word_r[WORD_W-1];
    assign bus.write_data_to_mem = word_r[WORD_W-2:0];
    assign bus.mem_write_from_io = mem_write_r;
    assign busy                  = busy_r;
    assign done                  = done_r;
    assign error                 = error_r;

endmodule

// File: tb/tb_io_tape_loader.sv
// Randomized bench for io_tape_loader with a word-level reference model and a 2-cycle memory responder.
module tb_io_tape_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] saddr_in = 12'd0;
    logic [11:0] count_in = 12'd0;
    logic        busy, done, error;

    io_tape_loader_if bus ();

    io_tape_loader dut (
        .clk                 (clk),
        .resetn              (resetn),
        .start_from_pnl      (start),
        .abort_from_pnl      (abort),
        .start_addr_from_pnl (saddr_in),
        .word_count_from_pnl (count_in),
        .bus                 (bus),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  frame_q[$];
    logic [31:0] exp_words[$];
    logic [11:0] wr_addr_q[$];
    logic [30:0] wr_data_q[$];
    int          n_done, busy_cycles, hold_bad, post_abort_busy;
    logic        err_final;

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) frame_q.push_back(4'((w >> (4 * (7 - i))) & 32'hF));
    endtask

    // mode: 0 plain, 1 abort the cycle after the first request, 2 abort in ASSEMBLE after arg frames, 3 stray start while busy
    task automatic run_job(input logic [11:0] sa, input logic [11:0] cnt, input int mode, input int arg);
        int age;
        bit pending;
        int popped;
        bit aborted;
        int cyc;
        logic [30:0] cur;
        wr_addr_q.delete(); wr_data_q.delete();
        n_done = 0; busy_cycles = 0; hold_bad = 0; post_abort_busy = -1;
        pending = 0; age = 0; popped = 0; aborted = 0; cur = 31'd0;
        @(negedge clk);
        saddr_in = sa; count_in = cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (aborted && post_abort_busy < 0) post_abort_busy = int'(busy);
            if (!busy) break;
            busy_cycles++;
            if (done) n_done++;
            abort = 1'b0; start = 1'b0; bus.mem_write_reply_to_io = 1'b0;
            if (bus.mem_write_from_io) begin
                pending = 1; age = 0;
                cur = {bus.write_sign_to_mem, bus.write_data_to_mem};
                wr_data_q.push_back(cur);
            end else if (pending) begin
                age++;
                if (age == 1) wr_addr_q.push_back(bus.addr_to_sel);
                else if (bus.addr_to_sel !== wr_addr_q[$]) hold_bad++;
                if ({bus.write_sign_to_mem, bus.write_data_to_mem} !== cur) hold_bad++;
                if (age == 1 && mode == 1 && wr_data_q.size() == 1) abort = 1'b1;
                if (age == 2) begin bus.mem_write_reply_to_io = 1'b1; pending = 0; end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.mem_write_reply_to_io = 1'b1;
            end
            if (mode == 3 && cyc == 4) begin start = 1'b1; saddr_in = ~sa; count_in = 12'd5; end
            bus.frame_valid = (frame_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.frame_data  = (frame_q.size() > 0) ? frame_q[0] : 4'($urandom_range(0, 15));
            if (mode == 2 && !aborted && bus.frame_ready && popped == arg) begin
                abort = 1'b1; bus.frame_valid = 1'b0; aborted = 1;
            end else if (bus.frame_valid && bus.frame_ready) begin
                void'(frame_q.pop_front());
                popped++;
            end
            @(negedge clk);
        end
        err_final = error;
        checks++;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL job_timeout busy still %b after %0d cycles, want 0", busy, cyc);
        end
        bus.frame_valid = 1'b0; bus.mem_write_reply_to_io = 1'b0; abort = 1'b0; start = 1'b0;
        frame_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, done, error}); end
        checks++;
        if ({bus.frame_ready, bus.mem_write_from_io} !== 2'b00) begin errors++; $display("FAIL reset_bus_ctl got %b want 00", {bus.frame_ready, bus.mem_write_from_io}); end
        checks++;
        if (bus.addr_to_sel !== 12'd0) begin errors++; $display("FAIL reset_addr got %o want 0", bus.addr_to_sel); end
        checks++;
        if ({bus.write_sign_to_mem, bus.write_data_to_mem} !== 31'd0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.write_sign_to_mem, bus.write_data_to_mem}); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transfers();
        logic [11:0] sa, cnt, ea;
        logic [31:0] w;
        logic [30:0] csum;
        logic        exp_err;
        for (int s = 0; s < 8; s++) begin
            sa  = 12'($urandom_range(0, 4095));
            cnt = 12'($urandom_range(1, 3));
            if (s == 0) begin sa = 12'o0100; cnt = 12'd2; end
            if (s == 1) begin sa = 12'o7777; cnt = 12'd2; end
            if (s == 2) cnt = 12'd0;
            if (s == 3) cnt = 12'd1;
            exp_words.delete();
            for (int k = 0; k < int'(cnt); k++) begin
                w = $urandom;
                if (s < 3 || $urandom_range(0, 3) != 0) w[31] = 1'b0;
                if (s == 3) w[31] = 1'b1;
                exp_words.push_back(w);
            end
            if (s == 0) begin exp_words[0] = 32'h01234567; exp_words[1] = 32'h76543210; end
            exp_err = 1'b0;
            csum = 31'd0;
            foreach (exp_words[k]) begin
                push_word(exp_words[k]);
                if (exp_words[k] >= 32'h80000000) exp_err = 1'b1;
                csum = csum + exp_words[k][30:0];
            end
`ifdef IO_TAPE_LOADER_CHECKSUM_EN
            if (cnt != 12'd0) push_word({1'b0, csum});
`endif
            run_job(sa, cnt, (s == 7) ? 3 : 0, 0);
            checks++;
            if (wr_data_q.size() != int'(cnt)) begin errors++; $display("FAIL s%0d_write_count got %0d want %0d", s, wr_data_q.size(), cnt); end
            for (int k = 0; k < int'(cnt) && k < wr_data_q.size() && k < wr_addr_q.size(); k++) begin
                ea = 12'((int'(sa) + k) % 4096);
                checks++;
                if (wr_addr_q[k] !== ea) begin errors++; $display("FAIL s%0d_addr%0d got %o want %o", s, k, wr_addr_q[k], ea); end
                checks++;
                if (wr_data_q[k] !== exp_words[k][30:0]) begin errors++; $display("FAIL s%0d_data%0d got %h want %h", s, k, wr_data_q[k], exp_words[k][30:0]); end
            end
            checks++;
            if (n_done != 1) begin errors++; $display("FAIL s%0d_done_pulses got %0d want 1", s, n_done); end
            checks++;
            if (err_final !== exp_err) begin errors++; $display("FAIL s%0d_error got %b want %b", s, err_final, exp_err); end
            checks++;
            if (hold_bad != 0) begin errors++; $display("FAIL s%0d_hold got %0d changes want 0", s, hold_bad); end
            if (s == 2) begin
                checks++;
                if (busy_cycles != 1) begin errors++; $display("FAIL zero_count_busy got %0d cycles want 1", busy_cycles); end
            end
        end
    endtask

    task automatic test_abort_write();
        logic [11:0] sa;
        sa = 12'($urandom_range(0, 4095));
        exp_words.delete();
        for (int k = 0; k < 2; k++) begin
            exp_words.push_back({1'b0, 31'($urandom)});
            push_word(exp_words[k]);
        end
        run_job(sa, 12'd2, 1, 0);
        checks++;
        if (wr_data_q.size() != 1) begin errors++; $display("FAIL abort_wr_count got %0d want 1", wr_data_q.size()); end
        if (wr_data_q.size() > 0 && wr_addr_q.size() > 0) begin
            checks++;
            if (wr_data_q[0] !== exp_words[0][30:0]) begin errors++; $display("FAIL abort_wr_data got %h want %h", wr_data_q[0], exp_words[0][30:0]); end
            checks++;
            if (wr_addr_q[0] !== sa) begin errors++; $display("FAIL abort_wr_addr got %o want %o", wr_addr_q[0], sa); end
        end
        checks++;
        if (n_done != 0) begin errors++; $display("FAIL abort_wr_done got %0d want 0", n_done); end
        checks++;
        if (err_final !== 1'b1) begin errors++; $display("FAIL abort_wr_error got %b want 1", err_final); end
    endtask

    task automatic test_abort_assemble();
        int arg;
        for (int r = 0; r < 3; r++) begin
            arg = $urandom_range(0, 15);
            for (int k = 0; k < 2; k++) push_word({1'b0, 31'($urandom)});
            run_job(12'($urandom_range(0, 4095)), 12'd2, 2, arg);
            checks++;
            if (wr_data_q.size() != ((arg >= 8) ? 1 : 0)) begin errors++; $display("FAIL abort_asm%0d_writes got %0d want %0d", r, wr_data_q.size(), (arg >= 8) ? 1 : 0); end
            checks++;
            if (post_abort_busy != 0) begin errors++; $display("FAIL abort_asm%0d_idle busy got %0d want 0", r, post_abort_busy); end
            checks++;
            if (n_done != 0) begin errors++; $display("FAIL abort_asm%0d_done got %0d want 0", r, n_done); end
            checks++;
            if (err_final !== 1'b1) begin errors++; $display("FAIL abort_asm%0d_error got %b want 1", r, err_final); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        saddr_in = 12'o1234; count_in = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.frame_valid = 1'b1; bus.frame_data = 4'(i);
            @(negedge clk);
        end
        resetn = 1'b0;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        checks++;
        if ({busy, bus.mem_write_from_io, bus.frame_ready} !== 3'b000) begin errors++; $display("FAIL reset_mid_ctl got %b want 000", {busy, bus.mem_write_from_io, bus.frame_ready}); end
        checks++;
        if (bus.addr_to_sel !== 12'd0) begin errors++; $display("FAIL reset_mid_addr got %o want 0", bus.addr_to_sel); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, bus.mem_write_from_io} !== 2'b00) begin errors++; $display("FAIL reset_mid_after got %b want 00", {busy, bus.mem_write_from_io}); end
    endtask

`ifdef IO_TAPE_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [30:0] csum;
        for (int v = 0; v < 2; v++) begin
            csum = 31'd0;
            for (int k = 0; k < 2; k++) begin
                logic [31:0] w;
                w = {1'b0, 31'($urandom)};
                push_word(w);
                csum = csum + w[30:0];
            end
            push_word({1'b0, csum + 31'(v)});
            run_job(12'($urandom_range(0, 4095)), 12'd2, 0, 0);
            checks++;
            if (wr_data_q.size() != 2) begin errors++; $display("FAIL csum%0d_writes got %0d want 2", v, wr_data_q.size()); end
            checks++;
            if (err_final !== 1'(v)) begin errors++; $display("FAIL csum%0d_error got %b want %0d", v, err_final, v); end
            checks++;
            if (n_done != 1) begin errors++; $display("FAIL csum%0d_done got %0d want 1", v, n_done); end
        end
    endtask
`endif

    initial begin
        bus.frame_valid = 1'b0;
        bus.frame_data = 4'd0;
        bus.mem_write_reply_to_io = 1'b0;
        test_reset();
        test_transfers();
        test_abort_write();
        test_abort_assemble();
        test_reset_mid();
`ifdef IO_TAPE_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
